// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered N-to-2^N one-hot decoder with a valid/ready
// select handshake and an automatic scan mode. The scan walks the one-hot
// output across all 2^N lines and holds each line for DWELL cycles.
module onehot_decoder_seq #(
   parameter int N     = 3,
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic              sel_valid,
   input  logic [N-1:0]      sel,
   output logic              sel_ready,
   output logic [2**N-1:0]   y,
   output logic              y_valid,
   output logic              scan_done
);

   localparam int W  = 2**N;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [W-1:0]  ONE   = W'(1);
   localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
   localparam logic [N:0]    VLAST = (N+1)'(W - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state;
   logic [N-1:0]    idx;
   logic [DW-1:0]   dcnt;
   logic [N:0]      vcnt;

   // Requests are taken only while idle and enabled.
   always_comb begin
      sel_ready = (state == IDLE) && en;
   end

   // Handshake, decode and scan sequencing with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         dcnt      <= '0;
         vcnt      <= '0;
         y         <= '0;
         y_valid   <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         case (state)
            IDLE: begin
               if (!en) begin
                  y       <= '0;
                  y_valid <= 1'b0;
               end else if (sel_valid) begin
                  y       <= ONE << sel;
                  y_valid <= 1'b1;
                  if (mode) begin
                     state <= SCAN;
                     idx   <= sel;
                     dcnt  <= '0;
                     vcnt  <= '0;
                  end
               end
            end
            SCAN: begin
               if (en) begin
                  if (dcnt == DLAST) begin
                     dcnt <= '0;
                     if (vcnt == VLAST) begin
                        state     <= IDLE;
                        idx       <= '0;
                        vcnt      <= '0;
                        y         <= '0;
                        y_valid   <= 1'b0;
                        scan_done <= 1'b1;
                     end else begin
                        vcnt <= vcnt + (N+1)'(1);
                        idx  <= idx + N'(1);
                        y    <= ONE << (idx + N'(1));
                     end
                  end else begin
                     dcnt <= dcnt + DW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready select handshake and an automatic scan mode. In scan mode it walks the one-hot output across every line for a programmable dwell time. It generalises the team's fixed 1-to-2 / 2-to-4 / 3-to-8 decoders. It sits between a control FSM and strobe-driven loads (LED/segment scanners, register-bank write enables), where outputs must be glitch-free and must hold for a known number of cycles.

## Interface
- N, default 3: select width; output width is 2^N; legal range N ≥ 1.
- DWELL, default 4: cycles each line stays asserted in scan mode; legal range DWELL ≥ 1.

Ports (name, direction, width, meaning):
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low freezes scan and blanks idle output.
- mode  in  1  0 = direct decode, 1 = scan; sampled only at handshake.
- sel_valid  in  1  request valid.
- sel  in  N  line index (decode) or scan start index (scan).
- sel_ready  out  1  request can be accepted; combinational = (state==IDLE) && en.
- y  out  2^N  registered one-hot output, or all-zero.
- y_valid  out  1  registered; high when y holds a one-hot code.
- scan_done  out  1  registered one-cycle pulse at scan completion.

## Operation
- States: IDLE, SCAN.
- Accept = sel_valid && sel_ready at a rising edge.
- IDLE, accept with mode=0:
  - y ← 1<<sel, y_valid ← 1, state stays IDLE.
  - y holds until the next accept, en low, or reset.
- IDLE, accept with mode=1:
  - idx ← sel, dwell counter ← 0, y ← 1<<sel, y_valid ← 1, state → SCAN.
- SCAN, en=1:
  - Dwell counter increments each cycle.
  - When the counter reaches DWELL-1 it clears, and idx ← idx+1 modulo 2^N (wrap from 2^N-1 to 0).
  - y ← 1<<idx; one visit-step counter tracks lines visited.
- SCAN exit:
  - Condition: the final dwell of the 2^N-th visited line (index sel-1 mod 2^N) completes.
  - Action: state → IDLE, y ← 0, y_valid ← 0, scan_done ← 1 for exactly one cycle.
- SCAN, en=0: all counters, idx, y and y_valid are frozen. Scan resumes exactly where it stopped when en returns high.
- IDLE, en=0: y ← 0 and y_valid ← 0 at the next edge; requests are not accepted.
- sel and mode are ignored unless accepted. Changing mode mid-scan has no effect.
- y is always all-zero or exactly one-hot; never multi-hot, never X after reset.
- Internal widths:
  - Dwell counter: clog2(DWELL) bits, minimum 1.
  - Visit counter: N+1 bits, so 2^N visits are counted without aliasing.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, y=0, y_valid=0, scan_done=0, all counters 0. sel_ready is high in the first cycle after release if en=1.
- Reset mid-scan aborts immediately; no scan_done is produced.
- Decode latency: y valid 1 cycle after the accept edge.
- Back-to-back decode accepts are allowed every cycle (throughput 1/cycle).
- Scan accepted at edge k:
  - Line j of the walk (j = 0..2^N-1) is asserted from edge k+j·DWELL to k+(j+1)·DWELL.
  - At edge k+2^N·DWELL: y=0, y_valid=0, scan_done=1, sel_ready=1 (with en=1).
  - A new request may be accepted in that same scan_done cycle.
- Each en-low cycle during a scan extends the total scan duration by one cycle.
- sel_ready is low for the entire SCAN state, including the last dwell cycle.

## Test plan
- Reset/decode, N=3: reset, then decode sel=5. Required: y=0x00 and y_valid=0 after reset; y=0x20 and y_valid=1 one cycle after accept. Then sel=0,7 on consecutive cycles gives y=0x01, then 0x80.
- Scan with wrap, N=3, DWELL=2, start sel=6. Required:
  - y sequence 0x40,0x40,0x80,0x80,0x01,0x01,…,0x20,0x20 (16 cycles).
  - Then y=0, scan_done=1 for one cycle, sel_ready=1.
  - sel_ready=0 throughout the scan.
- en pause: mid-scan, drop en for 3 cycles at the second cycle of line 0x04. Required: y stays 0x04 for those 3 cycles, the walk resumes with one remaining dwell cycle, and total scan length is 19 cycles.
- en in IDLE: after decode y=0x08, drop en. Required: y=0 and y_valid=0 next cycle; sel_ready=0; sel_valid is ignored until en=1.
- Reset mid-scan: assert rst asynchronously at line 0x10. Required: y=0, y_valid=0, and scan_done=0 immediately, with no done pulse after release.
- DWELL=1, N=1: scan from sel=1. Required: y=0b10, then 0b01, then 0 with scan_done the next cycle.
